stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_pkg.sv | 17 +
 rtl/stopwatch_ctrl_lim_inc.sv | 28 ++
 rtl/stopwatch_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_ctrl_pkg;

    // Controller states: IDLE is cleared and stopped, PAUSE keeps the count.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Digit rollover limits: decimal units and sexagesimal tens.
    localparam int unsigned LIM_DEC = 10;
    localparam int unsigned LIM_SEX = 6;

endpackage

// File: rtl/stopwatch_ctrl_lim_inc.sv
// Limited incrementor: one BCD digit plus carry-in, wrapping to 0 at L.
// Latency: purely combinational.
// Backpressure: none.
module Lim_Inc #(
    parameter int unsigned L = 10
) (
    input  logic [3:0] d_i,
    input  logic       ci_i,
    output logic [3:0] q_o,
    output logic       co_o
);

    localparam logic [3:0] LIM = 4'(L);

    logic [3:0] sum;

    // Add the carry; reaching the limit folds back to zero and carries out.
    always_comb begin
        sum  = d_i + {3'd0, ci_i};
        q_o  = sum;
        co_o = 1'b0;
        if (sum >= LIM) begin
            q_o  = 4'd0;
            co_o = 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch: trig toggles run/pause, init_regs clears, prescaler makes the tick.
// Latency: first increment on the CLK_DIV-th edge after entering RUN; outputs registered.
// Backpressure: none; trig and init_regs are single-cycle pulses, always accepted.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_regs,
    input  logic       trig,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    so_q, st_q, mo_q, mt_q;
    logic [3:0]    so_d, st_d, mo_d, mt_d;
    logic [3:0]    so_n, st_n, mo_n, mt_n;
    logic          running_q, wrap_q, wrap_d;
    logic          tick;
    logic          c1, c2, c3, c4;

    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    // Digit chain: each stage's carry-out feeds the next, all in one cycle.
    Lim_Inc #(.L(LIM_DEC)) u_sec_ones (.d_i(so_q), .ci_i(tick), .q_o(so_n), .co_o(c1));
    Lim_Inc #(.L(LIM_SEX)) u_sec_tens (.d_i(st_q), .ci_i(c1),   .q_o(st_n), .co_o(c2));
    Lim_Inc #(.L(LIM_DEC)) u_min_ones (.d_i(mo_q), .ci_i(c2),   .q_o(mo_n), .co_o(c3));
    Lim_Inc #(.L(LIM_SEX)) u_min_tens (.d_i(mt_q), .ci_i(c3),   .q_o(mt_n), .co_o(c4));

    // Next state: clear wins over trig; trig toggles between RUN and PAUSE.
    always_comb begin
        state_d = state_q;
        if (init_regs) begin
            state_d = ST_IDLE;
        end else if (trig) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Prescaler counts while RUN (including the pausing edge), holds in PAUSE, zero in IDLE.
    always_comb begin
        presc_d = presc_q;
        if (init_regs || state_q == ST_IDLE) begin
            presc_d = '0;
        end else if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Digits take the incremented chain unless cleared; wrap is min_tens carry-out.
    always_comb begin
        so_d   = so_n;
        st_d   = st_n;
        mo_d   = mo_n;
        mt_d   = mt_n;
        wrap_d = c4;
        if (init_regs) begin
            so_d   = 4'd0;
            st_d   = 4'd0;
            mo_d   = 4'd0;
            mt_d   = 4'd0;
            wrap_d = 1'b0;
        end
    end

    // State, prescaler, digits and flags all register on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            so_q      <= 4'd0;
            st_q      <= 4'd0;
            mo_q      <= 4'd0;
            mt_q      <= 4'd0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            so_q      <= so_d;
            st_q      <= st_d;
            mo_q      <= mo_d;
            mt_q      <= mt_d;
            running_q <= (state_d == ST_RUN);
            wrap_q    <= wrap_d;
        end
    end

    assign sec_ones = so_q;
    assign sec_tens = st_q;
    assign min_ones = mo_q;
    assign min_tens = mt_q;
    assign running  = running_q;
    assign wrap     = wrap_q;

endmodule
